// File: rtl/mel_band_accum.sv
// Mel filterbank accumulator: scans a spectrum buffer, splits each bin between two adjacent bands and streams per-band energies.
// Optional macro MEL_NORM_EN: when defined, outputs are rounded back to bin scale (>> W_WIDTH, round-half-up).
module mel_band_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_MEL    = 16,
    parameter int W_WIDTH    = 8,
    parameter int BAND_WIDTH = $clog2(NUM_MEL + 1),
    parameter int ACC_WIDTH  = DATA_WIDTH + W_WIDTH + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [BAND_WIDTH-1:0] coef_band,
    input  logic [W_WIDTH-1:0]    coef_w,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ACC_WIDTH-1:0]  m_data,
    output logic [BAND_WIDTH-1:0] m_index,
    output logic                  m_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int IDX_W = (NUM_MEL > 1) ? $clog2(NUM_MEL) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [BAND_WIDTH-1:0] LAST_BAND = BAND_WIDTH'(NUM_MEL - 1);
    localparam logic [W_WIDTH:0]      W_ONE     = {1'b1, {W_WIDTH{1'b0}}};

    function automatic logic [ACC_WIDTH-1:0] band_out(input logic [ACC_WIDTH-1:0] a);
`ifdef MEL_NORM_EN
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {{(ACC_WIDTH - W_WIDTH + 1){1'b0}}, 1'b1, {(W_WIDTH - 1){1'b0}}};
        return ACC_WIDTH'(s >> W_WIDTH);
`else
        return a;
`endif
    endfunction

    logic [1:0]            state;
    logic [ACC_WIDTH-1:0]  acc     [NUM_MEL];
    logic [ACC_WIDTH-1:0]  acc_nxt [NUM_MEL];

    logic [DATA_WIDTH-1:0] d_p1;
    logic [BAND_WIDTH-1:0] band_p1;
    logic [W_WIDTH-1:0]    w_p1;
    logic                  vld_p1;
    logic [ACC_WIDTH-1:0]  hi_p1;
    logic [ACC_WIDTH-1:0]  lo_p1;

    logic [BAND_WIDTH-1:0] nxt_index;
    logic [IDX_W-1:0]      nxt_sel;
    logic [ACC_WIDTH-1:0]  drain_data;

    assign busy = (state != S_IDLE);

    // Stage 0 -> 1: capture the bin and its coefficient while scanning
    always_ff @(posedge clk) begin
        if (state == S_SCAN) begin
            d_p1    <= rd_data;
            band_p1 <= coef_band;
            w_p1    <= coef_w;
        end
    end

    // Stage 1: weighted split; band b takes hi, band b-1 takes lo, out-of-range halves match no band
    assign hi_p1 = ACC_WIDTH'(d_p1) * ACC_WIDTH'(w_p1);
    assign lo_p1 = ACC_WIDTH'(d_p1) * ACC_WIDTH'(W_ONE - {1'b0, w_p1});

    always_comb begin
        for (int i = 0; i < NUM_MEL; i++) begin
            acc_nxt[i] = acc[i];
            if (vld_p1 && band_p1 == BAND_WIDTH'(i))
                acc_nxt[i] = acc[i] + hi_p1;
            if (vld_p1 && band_p1 == BAND_WIDTH'(i + 1))
                acc_nxt[i] = acc[i] + lo_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MEL; i++)
                acc[i] <= '0;
        end else if (state == S_IDLE && start) begin
            for (int i = 0; i < NUM_MEL; i++)
                acc[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MEL; i++)
                acc[i] <= acc_nxt[i];
        end
    end

    assign nxt_index  = m_index + 1'b1;
    assign nxt_sel    = nxt_index[IDX_W-1:0];
    assign drain_data = band_out(acc[nxt_sel]);

    // Stage 2: output register, loaded from the post-flush sum and then on each handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            rd_addr <= '0;
            vld_p1  <= 1'b0;
            done    <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_index <= '0;
            m_last  <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_p1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rd_addr <= '0;
                        state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    vld_p1 <= 1'b1;
                    if (rd_addr == LAST_ADDR) begin
                        rd_addr <= '0;
                        state   <= S_FLUSH;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_FLUSH: begin
                    state   <= S_DRAIN;
                    m_valid <= 1'b1;
                    m_index <= '0;
                    m_data  <= band_out(acc_nxt[0]);
                    m_last  <= (LAST_BAND == '0);
                end
                S_DRAIN: begin
                    if (m_valid && m_ready) begin
                        if (m_index == LAST_BAND) begin
                            state   <= S_IDLE;
                            done    <= 1'b1;
                            m_valid <= 1'b0;
                            m_data  <= '0;
                            m_index <= '0;
                            m_last  <= 1'b0;
                        end else begin
                            m_index <= nxt_index;
                            m_data  <= drain_data;
                            m_last  <= (nxt_index == LAST_BAND);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mel_band_accum.sv
// Self-checking bench for mel_band_accum: randomized frames against a per-bin arithmetic reference model.
module tb_mel_band_accum;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 128;
    localparam int ADDR_WIDTH = 7;
    localparam int NUM_MEL    = 16;
    localparam int W_WIDTH    = 8;
    localparam int BAND_WIDTH = 5;
    localparam int ACC_WIDTH  = DATA_WIDTH + W_WIDTH + ADDR_WIDTH;
    localparam int BUDGET     = DEPTH + 8 * NUM_MEL + 300;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [BAND_WIDTH-1:0] coef_band;
    logic [W_WIDTH-1:0]    coef_w;
    logic                  m_valid;
    logic                  m_ready;
    logic [ACC_WIDTH-1:0]  m_data;
    logic [BAND_WIDTH-1:0] m_index;
    logic                  m_last;

    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [BAND_WIDTH-1:0] mem_b [DEPTH];
    logic [W_WIDTH-1:0]    mem_w [DEPTH];

    logic [ACC_WIDTH-1:0]  exp_out  [NUM_MEL];
    logic [ACC_WIDTH-1:0]  got_data [NUM_MEL+4];
    logic [BAND_WIDTH-1:0] got_idx  [NUM_MEL+4];
    logic                  got_last [NUM_MEL+4];

    int checks = 0;
    int errors = 0;
    int cyc, n_xfer, first_valid, done_cyc, addr_bad, hold_bad, hold_checks;
    logic busy_at_done, timeout;

    assign rd_data   = mem_d[rd_addr];
    assign coef_band = mem_b[rd_addr];
    assign coef_w    = mem_w[rd_addr];

    mel_band_accum #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_MEL(NUM_MEL),
        .W_WIDTH(W_WIDTH), .BAND_WIDTH(BAND_WIDTH), .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .coef_band(coef_band), .coef_w(coef_w),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each bin adds d*w to band b and d*(256-w) to band b-1, if those bands exist.
    task automatic build_model();
        longint e [NUM_MEL];
        longint d, b, w;
        for (int i = 0; i < NUM_MEL; i++) e[i] = 0;
        for (int k = 0; k < DEPTH; k++) begin
            d = longint'(mem_d[k]);
            b = longint'(mem_b[k]);
            w = longint'(mem_w[k]);
            if (b < NUM_MEL) e[b] += d * w;
            if (b >= 1 && b <= NUM_MEL) e[b-1] += d * ((1 << W_WIDTH) - w);
        end
        for (int i = 0; i < NUM_MEL; i++) begin
`ifdef MEL_NORM_EN
            e[i] = (e[i] + (1 << (W_WIDTH - 1))) >> W_WIDTH;
`endif
            exp_out[i] = e[i][ACC_WIDTH-1:0];
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < DEPTH; k++) begin
            mem_d[k] = DATA_WIDTH'($urandom);
            mem_b[k] = BAND_WIDTH'($urandom_range(0, NUM_MEL + 3));
            mem_w[k] = W_WIDTH'($urandom);
        end
    endtask

    task automatic fill_const(input int d, input int b, input int w);
        for (int k = 0; k < DEPTH; k++) begin
            mem_d[k] = DATA_WIDTH'(d);
            mem_b[k] = BAND_WIDTH'(b);
            mem_w[k] = W_WIDTH'(w);
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
    endtask

    // Runs the frame to its done pulse, recording transfers; mode 0 ready high, 1 alternating, 2 random.
    task automatic collect(input int mode, input int poke_cyc);
        logic                  stall;
        logic [ACC_WIDTH-1:0]  pd;
        logic [BAND_WIDTH-1:0] pi;
        logic                  pl;
        n_xfer = 0; first_valid = -1; done_cyc = -1; busy_at_done = 1'b1; timeout = 1'b0;
        addr_bad = 0; hold_bad = 0; hold_checks = 0;
        stall = 1'b0; pd = '0; pi = '0; pl = 1'b0;
        forever begin
            if (done) begin
                done_cyc = cyc; busy_at_done = busy; m_ready = 1'b0; start = 1'b0;
                break;
            end
            if (cyc >= 1 && cyc <= DEPTH && rd_addr != ADDR_WIDTH'(cyc - 1)) addr_bad++;
            start = (cyc == poke_cyc);
            if (stall) begin
                hold_checks++;
                if (!m_valid || m_data !== pd || m_index !== pi || m_last !== pl) hold_bad++;
            end
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                if (n_xfer < NUM_MEL + 4) begin
                    got_data[n_xfer] = m_data;
                    got_idx[n_xfer]  = m_index;
                    got_last[n_xfer] = m_last;
                end
                n_xfer++;
            end
            stall = m_valid && !m_ready;
            pd = m_data; pi = m_index; pl = m_last;
            if (cyc > BUDGET) begin
                timeout = 1'b1; m_ready = 1'b0; start = 1'b0;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got %0d want 0", m_data); end
        checks++; if (m_index !== '0) begin errors++; $display("FAIL reset_m_index got %0d want 0", m_index); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %0b want 0", m_last); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_split();
        logic [ACC_WIDTH-1:0] want_split;
`ifdef MEL_NORM_EN
        want_split = ACC_WIDTH'(64);
`else
        want_split = ACC_WIDTH'(16384);
`endif
        fill_const(1, 1, 128);
        build_model();
        start_frame();
        collect(0, -1);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL split_timeout got %0b want 0", timeout); end
        checks++; if (addr_bad != 0) begin errors++; $display("FAIL split_rd_addr_schedule got %0d bad cycles want 0", addr_bad); end
        checks++; if (first_valid != DEPTH + 2) begin errors++; $display("FAIL split_first_valid got %0d want %0d", first_valid, DEPTH + 2); end
        checks++; if (done_cyc != DEPTH + 2 + NUM_MEL) begin errors++; $display("FAIL split_done_cycle got %0d want %0d", done_cyc, DEPTH + 2 + NUM_MEL); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL split_busy_at_done got %0b want 0", busy_at_done); end
        checks++; if (n_xfer != NUM_MEL) begin errors++; $display("FAIL split_xfers got %0d want %0d", n_xfer, NUM_MEL); end
        checks++; if (got_data[0] !== want_split || got_data[1] !== want_split) begin
            errors++; $display("FAIL split_band01 got %0d,%0d want %0d", got_data[0], got_data[1], want_split);
        end
        for (int i = 0; i < NUM_MEL && i < n_xfer; i++) begin
            checks++;
            if (got_data[i] !== exp_out[i] || got_idx[i] !== BAND_WIDTH'(i) || got_last[i] !== (i == NUM_MEL - 1)) begin
                errors++;
                $display("FAIL split_band[%0d] got data %0d idx %0d last %0b want data %0d idx %0d last %0b",
                         i, got_data[i], got_idx[i], got_last[i], exp_out[i], i, (i == NUM_MEL - 1));
            end
        end
    endtask

    task automatic test_edges();
        fill_random();
        for (int k = 0; k < DEPTH; k++) mem_d[k] = '0;
        mem_d[0] = 16'd1000; mem_b[0] = 5'd0;  mem_w[0] = 8'd255;
        mem_d[5] = 16'd1000; mem_b[5] = 5'd16; mem_w[5] = 8'd0;
        build_model();
        start_frame();
        collect(2, -1);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL edges_timeout got %0b want 0", timeout); end
        checks++; if (n_xfer != NUM_MEL) begin errors++; $display("FAIL edges_xfers got %0d want %0d", n_xfer, NUM_MEL); end
        for (int i = 0; i < NUM_MEL && i < n_xfer; i++) begin
            checks++;
            if (got_data[i] !== exp_out[i] || got_idx[i] !== BAND_WIDTH'(i)) begin
                errors++;
                $display("FAIL edges_band[%0d] got data %0d idx %0d want data %0d idx %0d", i, got_data[i], got_idx[i], exp_out[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        fill_random();
        build_model();
        start_frame();
        collect(1, -1);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout got %0b want 0", timeout); end
        checks++; if (hold_checks == 0 || hold_bad != 0) begin
            errors++; $display("FAIL bp_hold got %0d unstable of %0d stalls want 0 of >0", hold_bad, hold_checks);
        end
        checks++; if (n_xfer != NUM_MEL) begin errors++; $display("FAIL bp_xfers got %0d want %0d", n_xfer, NUM_MEL); end
        for (int i = 0; i < NUM_MEL && i < n_xfer; i++) begin
            checks++;
            if (got_data[i] !== exp_out[i] || got_idx[i] !== BAND_WIDTH'(i) || got_last[i] !== (i == NUM_MEL - 1)) begin
                errors++;
                $display("FAIL bp_band[%0d] got data %0d idx %0d last %0b want data %0d idx %0d", i, got_data[i], got_idx[i], got_last[i], exp_out[i], i);
            end
        end
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
                errors++; $display("FAIL bp_after_done[%0d] got done %0b busy %0b valid %0b want 0 0 0", j, done, busy, m_valid);
            end
        end
    endtask

    task automatic test_start_busy();
        fill_random();
        build_model();
        start_frame();
        collect(0, 40);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL startbusy_timeout got %0b want 0", timeout); end
        checks++; if (first_valid != DEPTH + 2 || addr_bad != 0) begin
            errors++; $display("FAIL startbusy_schedule got first_valid %0d addr_bad %0d want %0d 0", first_valid, addr_bad, DEPTH + 2);
        end
        for (int i = 0; i < NUM_MEL && i < n_xfer; i++) begin
            checks++;
            if (got_data[i] !== exp_out[i]) begin
                errors++; $display("FAIL startbusy_band[%0d] got %0d want %0d", i, got_data[i], exp_out[i]);
            end
        end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startbusy_no_requeue got busy %0b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int waited;
        fill_const(5000, 3, 77);
        start_frame();
        waited = 0;
        while (rd_addr != ADDR_WIDTH'(60) && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++; if (rd_addr !== ADDR_WIDTH'(60)) begin errors++; $display("FAIL rstmid_reach got rd_addr %0d want 60", rd_addr); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || rd_addr !== '0) begin
            errors++; $display("FAIL rstmid_immediate got busy %0b rd_addr %0d want 0 0", busy, rd_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        fill_random();
        build_model();
        start_frame();
        collect(0, -1);
        checks++; if (timeout !== 1'b0 || n_xfer != NUM_MEL) begin
            errors++; $display("FAIL rstmid_frame got timeout %0b xfers %0d want 0 %0d", timeout, n_xfer, NUM_MEL);
        end
        for (int i = 0; i < NUM_MEL && i < n_xfer; i++) begin
            checks++;
            if (got_data[i] !== exp_out[i]) begin
                errors++; $display("FAIL rstmid_band[%0d] got %0d want %0d", i, got_data[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [ACC_WIDTH-1:0] want_b2b;
`ifdef MEL_NORM_EN
        want_b2b = ACC_WIDTH'(128);
`else
        want_b2b = ACC_WIDTH'(32768);
`endif
        fill_random();
        build_model();
        start_frame();
        collect(0, -1);
        for (int i = 0; i < NUM_MEL && i < n_xfer; i++) begin
            checks++;
            if (got_data[i] !== exp_out[i]) begin
                errors++; $display("FAIL b2b_first_band[%0d] got %0d want %0d", i, got_data[i], exp_out[i]);
            end
        end
        fill_const(2, 1, 128);
        build_model();
        start_frame();
        collect(0, -1);
        checks++; if (timeout !== 1'b0 || first_valid != DEPTH + 2) begin
            errors++; $display("FAIL b2b_restart got timeout %0b first_valid %0d want 0 %0d", timeout, first_valid, DEPTH + 2);
        end
        checks++; if (got_data[0] !== want_b2b || got_data[1] !== want_b2b) begin
            errors++; $display("FAIL b2b_band01 got %0d,%0d want %0d", got_data[0], got_data[1], want_b2b);
        end
        for (int i = 0; i < NUM_MEL && i < n_xfer; i++) begin
            checks++;
            if (got_data[i] !== exp_out[i]) begin
                errors++; $display("FAIL b2b_second_band[%0d] got %0d want %0d", i, got_data[i], exp_out[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; cyc = 0;
        fill_const(0, 0, 0);
        test_reset();
        test_split();
        test_edges();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mel_band_accum.md
# mel_band_accum

Downstream consumer of the spectrum register buffer. After a frame is loaded into the buffer, it scans every bin through the buffer's asynchronous read port and applies sparse triangular mel weights from an external coefficient ROM. Each bin is split between two adjacent bands, and the block emits one accumulated energy per mel band over a valid/ready stream.

## Interface
- DATA_WIDTH, 16, bin sample width; matches the buffer word.
- DEPTH, 128, bins per frame; matches the buffer depth.
- ADDR_WIDTH, $clog2(DEPTH), bin address width.
- NUM_MEL, 16, number of mel bands output.
- W_WIDTH, 8, weight fraction bits; weight w means w/2^W_WIDTH.
- BAND_WIDTH, $clog2(NUM_MEL+1), band index width; covers 0..NUM_MEL.
- ACC_WIDTH, DATA_WIDTH+W_WIDTH+ADDR_WIDTH, accumulator and output width; wide enough that overflow cannot occur.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  frame ready; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output handshake.
- rd_addr  out  ADDR_WIDTH  drives buffer read_addr and coefficient ROM address.
- rd_data  in  DATA_WIDTH  buffer read_data; combinational from rd_addr.
- coef_band  in  BAND_WIDTH  upper band b of the bin; combinational from rd_addr.
- coef_w  in  W_WIDTH  weight of band b; band b-1 receives 2^W_WIDTH - w.
- m_valid  out  1  output band valid.
- m_ready  in  1  consumer ready.
- m_data  out  ACC_WIDTH  band energy.
- m_index  out  BAND_WIDTH  band number, 0..NUM_MEL-1.
- m_last  out  1  high with m_index = NUM_MEL-1.

## Operation
The FSM has four states: IDLE, SCAN, FLUSH and DRAIN.
- **IDLE, start=1:** clear all NUM_MEL accumulators, set rd_addr=0, go to SCAN.
- **SCAN:** on each cycle, register {rd_data, coef_band, coef_w} into the stage-1 pipeline register, then increment rd_addr.
  - After rd_addr=DEPTH-1 is captured, go to FLUSH.
  - rd_addr wraps to 0 after the last bin; it does not overflow.
- **Stage 1 (active in SCAN and FLUSH, one cycle behind capture):**
  - hi = d*w and lo = d*(2^W_WIDTH - w), both unsigned and zero-extended to ACC_WIDTH.
  - acc[b] += hi when b < NUM_MEL; otherwise hi is discarded.
  - acc[b-1] += lo when 1 ≤ b ≤ NUM_MEL; when b = 0, lo is discarded.
  - coef_band > NUM_MEL: both hi and lo are discarded.
  - The two additions in one cycle always target different bands, so there is no conflict.
- **FLUSH:** one cycle; stage 1 accumulates the last captured bin. Then go to DRAIN with index=0.
- **DRAIN:**
  - m_valid=1, m_index=index, m_data=out(acc[index]).
  - On m_valid&&m_ready: advance index. If index was NUM_MEL-1, go to IDLE and pulse done for one cycle.
  - While m_valid&&!m_ready, m_data, m_index and m_last hold stable.
- **start while busy:** ignored, not queued.
- **Buffer ownership:** the upstream writer must not write the buffer while busy=1. The block accumulates whatever rd_data presents.
- **rst at any time:** immediately returns to IDLE and clears accumulators and all outputs. A partial frame is abandoned and produces no output.

## Timing
- **Reset values:** busy=0, done=0, m_valid=0, m_data=0, m_index=0, m_last=0, rd_addr=0.
- **Scan schedule** (start sampled high at edge 0):
  - rd_addr=k during cycle k+1, for k = 0..DEPTH-1.
  - FLUSH runs in cycle DEPTH+1.
  - First m_valid is in cycle DEPTH+2.
- **Stream:** m_data is registered and changes only on a handshake. With m_ready held high, one band transfers per cycle.
- **Frame period:** DEPTH+2+NUM_MEL cycles with no backpressure.
- **done:** high in the cycle after the final handshake; busy=0 in that same cycle.
- **Restart:** start may be reasserted in the cycle done is high.

## Configuration
- Macro `MEL_NORM_EN`:
  - **Defined:** m_data = (acc + 2^(W_WIDTH-1)) >> W_WIDTH, round-half-up, zero-extended to ACC_WIDTH. This restores the bin scale.
  - **Undefined:** m_data = acc, full precision with no rounding logic.
- Accumulation is identical in both builds; only the output stage differs.

## Test plan
- **Split:** all bins rd_data=1, coef_band=1, coef_w=128 → band0=16384, band1=16384, bands 2..15=0, m_last on index 15. With MEL_NORM_EN: 64 each.
- **Edges:** bin 0 has d=1000, b=0, w=255; all other bins have d=0 → band0=255000, lo discarded, all other bands 0. Bin 5 has d=1000, b=16, w=0 → band15=256000, hi discarded.
- **Backpressure:** toggle m_ready 1010…; drop it during index 3 → data/index hold stable; exactly 16 transfers; done pulses once after index 15.
- **Start during busy:** pulse start in cycle 40 of SCAN → no restart; output is the same as the unperturbed run.
- **Reset mid-SCAN:** assert rst at rd_addr=60 → busy=0 and rd_addr=0 immediately; a new start produces correct fresh sums with no carry-over.
- **Back-to-back:** restart in the done cycle with a different frame (d=2 everywhere, b=1, w=128) → second-frame band0 = band1 = 32768.
